instruction_fetch_unit: RTL

//  IF stage directly downstream of hazard_detection_unit: owns the PC, issues in-order

---
 rtl/instruction_fetch_unit_if.sv | 34 +++
 rtl/instruction_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Instruction-memory request/response bus between the fetch unit and the
//   instruction memory.
//   imem_req_o    : fetch request valid (fetch -> memory)
//   imem_addr_o   : word-aligned fetch address (fetch -> memory)
//   imem_ready_i  : memory accepts the request when req & ready (memory -> fetch)
//   imem_rvalid_i : in-order response valid, one per accepted request
//   imem_rdata_i  : instruction word of the response
//   Modports: master = fetch unit side, slave = memory side.
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   IF stage: owns the PC, issues in-order requests to instruction memory,
//   buffers returned words in a small FIFO and loads the IF/ID register.
//   Honours stall / flush / redirect from the hazard unit and discards any
//   responses that belong to a squashed fetch path.
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   pc_write_en_i           : 0 = no new memory request
//   if_id_write_en_i        : 0 = hold IF/ID contents
//   if_id_flush_i           : clear IF/ID valid
//   take_branch_i           : redirect fetch to branch_target_pc_i
//   branch_target_pc_i      : redirect target
//   imem                    : instruction-memory bus (master side)
//   if_pc_o                 : PC of the next request
//   if_id_valid_o/pc/instr  : IF/ID register
//   fetch_misalign_o        : one-cycle pulse when a redirect target is unaligned
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pc_write_en_i,
  input  logic                            if_id_write_en_i,
  input  logic                            if_id_flush_i,
  input  logic                            take_branch_i,
  input  logic [31:0]                     branch_target_pc_i,
  instruction_fetch_unit_if.master        imem,
  output logic [31:0]                     if_pc_o,
  output logic                            if_id_valid_o,
  output logic [31:0]                     if_id_pc_o,
  output logic [31:0]                     if_id_instr_o,
  output logic                            fetch_misalign_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   pc_reg;
  logic [CW-1:0] out_cnt_reg;
  logic [CW-1:0] drop_cnt_reg;
  logic          misalign_reg;

  // PCs of accepted requests, in issue order; popped by every response
  // (kept or dropped) so its head always names the returning word.
  logic [31:0]   ifq_pc_mem [FIFO_DEPTH];
  logic [PW-1:0] ifq_wr_reg, ifq_rd_reg;

  // Return buffer of {pc, instr}.
  logic [31:0]   rb_pc_mem    [FIFO_DEPTH];
  logic [31:0]   rb_instr_mem [FIFO_DEPTH];
  logic [PW-1:0] rb_wr_reg, rb_rd_reg;
  logic [CW-1:0] rb_cnt_reg;

  logic          if_id_valid_reg;
  logic [31:0]   if_id_pc_reg, if_id_instr_reg;

  logic credit_ok, req, accept, rsp_keep, squash, if_id_load;
  logic rb_empty, rb_pop, bypass, rb_push;

  // Outstanding requests plus buffered words never exceed the buffer size,
  // so every response that is kept always has a slot waiting for it.
  assign credit_ok  = ({1'b0, out_cnt_reg} + {1'b0, rb_cnt_reg}) < DEPTH_W;
  assign req        = !rst && pc_write_en_i && !take_branch_i && credit_ok;
  assign accept     = req && imem.imem_ready_i;
  // A response is discarded if it belongs to an older path, including one
  // that lands in the very cycle of a redirect.
  assign rsp_keep   = imem.imem_rvalid_i && (drop_cnt_reg == '0) && !take_branch_i;
  assign squash     = take_branch_i || if_id_flush_i;
  assign if_id_load = !squash && if_id_write_en_i;
  assign rb_empty   = (rb_cnt_reg == '0);
  assign rb_pop     = if_id_load && !rb_empty;
  assign bypass     = if_id_load && rb_empty && rsp_keep;
  assign rb_push    = rsp_keep && !bypass;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_reg;
  assign if_pc_o          = pc_reg;
  assign if_id_valid_o    = if_id_valid_reg;
  assign if_id_pc_o       = if_id_pc_reg;
  assign if_id_instr_o    = if_id_instr_reg;
  assign fetch_misalign_o = misalign_reg;

  // Storage arrays carry no reset; validity lives in the pointers/counters.
  always_ff @(posedge clk) begin
    if (accept) begin
      ifq_pc_mem[ifq_wr_reg] <= pc_reg;
    end
    if (rb_push) begin
      rb_pc_mem[rb_wr_reg]    <= ifq_pc_mem[ifq_rd_reg];
      rb_instr_mem[rb_wr_reg] <= imem.imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      out_cnt_reg     <= '0;
      drop_cnt_reg    <= '0;
      misalign_reg    <= 1'b0;
      ifq_wr_reg      <= '0;
      ifq_rd_reg      <= '0;
      rb_wr_reg       <= '0;
      rb_rd_reg       <= '0;
      rb_cnt_reg      <= '0;
      if_id_valid_reg <= 1'b0;
      if_id_pc_reg    <= '0;
      if_id_instr_reg <= '0;
    end else begin
      misalign_reg <= take_branch_i && (branch_target_pc_i[1:0] != 2'b00);

      if (take_branch_i) begin
        pc_reg <= {branch_target_pc_i[31:2], 2'b00};
      end else if (accept) begin
        pc_reg <= pc_reg + 32'd4;
      end

      out_cnt_reg <= out_cnt_reg + CW'(accept) - CW'(imem.imem_rvalid_i);
      if (accept) begin
        ifq_wr_reg <= ptr_inc(ifq_wr_reg);
      end
      if (imem.imem_rvalid_i) begin
        ifq_rd_reg <= ptr_inc(ifq_rd_reg);
      end

      // Everything still in flight after a redirect belongs to the old path.
      if (take_branch_i) begin
        drop_cnt_reg <= out_cnt_reg - CW'(imem.imem_rvalid_i);
      end else if (imem.imem_rvalid_i && (drop_cnt_reg != '0)) begin
        drop_cnt_reg <= drop_cnt_reg - CW'(1);
      end

      if (take_branch_i) begin
        rb_wr_reg  <= '0;
        rb_rd_reg  <= '0;
        rb_cnt_reg <= '0;
      end else begin
        if (rb_push) begin
          rb_wr_reg <= ptr_inc(rb_wr_reg);
        end
        if (rb_pop) begin
          rb_rd_reg <= ptr_inc(rb_rd_reg);
        end
        rb_cnt_reg <= rb_cnt_reg + CW'(rb_push) - CW'(rb_pop);
      end

      if (squash) begin
        if_id_valid_reg <= 1'b0;
      end else if (if_id_write_en_i) begin
        if (rb_pop) begin
          if_id_valid_reg <= 1'b1;
          if_id_pc_reg    <= rb_pc_mem[rb_rd_reg];
          if_id_instr_reg <= rb_instr_mem[rb_rd_reg];
        end else if (bypass) begin
          if_id_valid_reg <= 1'b1;
          if_id_pc_reg    <= ifq_pc_mem[ifq_rd_reg];
          if_id_instr_reg <= imem.imem_rdata_i;
        end else begin
          if_id_valid_reg <= 1'b0;
        end
      end
    end
  end

  // Credit accounting makes these unreachable; they flag a broken memory
  // model or a broken credit check.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    rb_push |-> ((rb_cnt_reg != CW'(FIFO_DEPTH)) || rb_pop));
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst)
    imem.imem_rvalid_i |-> (out_cnt_reg != '0));

endmodule
